// File: rtl/snake_dir_queue.sv
// snake_dir_queue: per-player key edge detect, turn legality filter and tick-drained turn FIFO (clk, reset active-low async, key_* in, tick in, direction/q_count/overflow out)
module snake_dir_queue #(
  parameter int NUM_PLAYERS = 2,
  parameter int QUEUE_DEPTH = 3,
  parameter logic [1:0] INIT_DIR = 2'b00,
  parameter int CW = $clog2(QUEUE_DEPTH + 1)
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NUM_PLAYERS-1:0]    key_right,
  input  logic [NUM_PLAYERS-1:0]    key_down,
  input  logic [NUM_PLAYERS-1:0]    key_left,
  input  logic [NUM_PLAYERS-1:0]    key_up,
  input  logic                      tick,
  output logic [2*NUM_PLAYERS-1:0]  direction,
  output logic [CW*NUM_PLAYERS-1:0] q_count,
  output logic [NUM_PLAYERS-1:0]    overflow
);
  localparam int PW = QUEUE_DEPTH > 1 ? $clog2(QUEUE_DEPTH) : 1;
  localparam logic [PW-1:0] LAST = PW'(QUEUE_DEPTH - 1);
  localparam logic [CW-1:0] FULL = CW'(QUEUE_DEPTH);
  for (genvar p = 0; p < NUM_PLAYERS; p++) begin : g_p
    logic [3:0] keys, key_q, rise;
    logic [1:0] dir, new_dir, tail, ref_dir;
    logic [1:0] mem [QUEUE_DEPTH];
    logic [PW-1:0] rd, wr;
    logic [CW-1:0] cnt;
    logic ovf, valid, acc, pop, bypass, push;
    always_comb begin
      keys = {key_up[p], key_left[p], key_down[p], key_right[p]};
      rise = keys & ~key_q;
      valid = rise != 4'd0 && (rise & (rise - 4'd1)) == 4'd0;
      new_dir = rise[3] ? 2'd3 : rise[2] ? 2'd2 : rise[1] ? 2'd1 : 2'd0;
      tail = mem[wr == '0 ? LAST : wr - 1'b1];
      ref_dir = cnt != '0 ? tail : dir;
      acc = valid && new_dir != ref_dir && new_dir != (ref_dir ^ 2'b10);
      pop = tick && cnt != '0;
      bypass = tick && cnt == '0 && acc;
      push = acc && !bypass && (cnt != FULL || pop);
    end
    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        key_q <= '1;
        dir <= INIT_DIR;
        rd <= '0;
        wr <= '0;
        cnt <= '0;
        ovf <= 1'b0;
      end else begin
        key_q <= keys;
        dir <= pop ? mem[rd] : bypass ? new_dir : dir;
        rd <= pop ? (rd == LAST ? '0 : rd + 1'b1) : rd;
        wr <= push ? (wr == LAST ? '0 : wr + 1'b1) : wr;
        cnt <= cnt + CW'(push) - CW'(pop);
        ovf <= acc && !tick && cnt == FULL;
      end
    end
    always_ff @(posedge clk) begin
      if (push) mem[wr] <= new_dir;
    end
    assign direction[2*p +: 2] = dir;
    assign q_count[CW*p +: CW] = cnt;
    assign overflow[p] = ovf;
  end
endmodule
